// File: rtl/reg_select_decoder_if.sv
// reg_select_decoder_if: control inputs and select outputs
// of the one-hot register select decoder.
interface reg_select_decoder_if #(
  parameter int SEL_W = 4
) ();
  localparam int OUT_W = 2**SEL_W;

  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             start;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] index;
  logic             busy;
  logic             done;

  modport master (
    output mode, sel, en, start,
    input  out, index, busy, done
  );

  modport slave (
    input  mode, sel, en, start,
    output out, index, busy, done
  );
endinterface

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: registered one-hot select generator
// with decode, continuous scan and one-shot sweep modes.
module reg_select_decoder #(
  parameter int SEL_W    = 4,
  parameter int SCAN_DIV = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_select_decoder_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = '1;

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_DEC  = 2'b01;
  localparam logic [1:0] M_SCAN = 2'b10;
  localparam logic [1:0] M_SWP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    SCAN,
    SWP
  } state_t;

  state_t           state_q;
  logic [OUT_W-1:0] out_q;
  logic [SEL_W-1:0] index_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [SEL_W-1:0] idx_inc;
  logic             scan_entry;
  logic             slot_end;

  function automatic logic [OUT_W-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    return OUT_W'(1) << i;
  endfunction

  function automatic state_t state_of(
    input logic [1:0] m
  );
    state_t s;
    unique case (m)
      M_OFF:   s = IDLE;
      M_DEC:   s = DEC;
      M_SCAN:  s = SCAN;
      default: s = SWP;
    endcase
    return s;
  endfunction

  // Scan restarts at 0 when coming from another state, or
  // when an aborted sweep parked us in SCAN with out cleared.
  always_comb begin
    idx_inc    = index_q + 1'b1;
    scan_entry = (state_q != SCAN) || (out_q == '0);
    slot_end   = (cnt_q == CNT_LAST);
  end

  // Mode FSM with registered select, index and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      index_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == SWP && bus.mode != M_SWP) begin
        busy_q  <= 1'b0;
        out_q   <= '0;
        state_q <= state_of(bus.mode);
      end else begin
        unique case (bus.mode)
          M_OFF: begin
            state_q <= IDLE;
            out_q   <= '0;
          end
          M_DEC: begin
            state_q <= DEC;
            if (bus.en) begin
              out_q   <= onehot(bus.sel);
              index_q <= bus.sel;
            end else begin
              out_q <= '0;
            end
          end
          M_SCAN: begin
            state_q <= SCAN;
            if (scan_entry) begin
              index_q <= '0;
              out_q   <= onehot('0);
              cnt_q   <= '0;
            end else if (slot_end) begin
              cnt_q   <= '0;
              index_q <= idx_inc;
              out_q   <= onehot(idx_inc);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            if (state_q == SWP) begin
              if (!slot_end) begin
                cnt_q <= cnt_q + 1'b1;
              end else if (index_q == IDX_LAST) begin
                busy_q  <= 1'b0;
                out_q   <= '0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                cnt_q   <= '0;
                index_q <= idx_inc;
                out_q   <= onehot(idx_inc);
              end
            end else if (bus.start) begin
              state_q <= SWP;
              busy_q  <= 1'b1;
              index_q <= '0;
              out_q   <= onehot('0);
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
              out_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.out   = out_q;
  assign bus.index = index_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
